// File: rtl/led_pwm_pio_pkg.sv
// Shared register map and STATUS layout for the LED PWM PIO block.
package led_pwm_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd3;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd4;
  localparam logic [2:0] ADDR_DUTY      = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STATUS_PHASE_BIT   = 0;
  localparam int STATUS_PENDING_BIT = 1;

  function automatic logic [31:0] status_word(input logic phase, input logic pending);
    logic [31:0] w;
    w = '0;
    w[STATUS_PHASE_BIT]   = phase;
    w[STATUS_PENDING_BIT] = pending;
    return w;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM counter with period-aligned duty update, plus the blink phase divider.
module led_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                duty_we_i,
  input  logic [PWM_BITS:0]   duty_wdata_i,
  input  logic                div_we_i,
  input  logic [BLINK_W-1:0]  div_wdata_i,
  output logic                pwm_on_o,
  output logic                phase_o,
  output logic                pending_o,
  output logic [PWM_BITS:0]   duty_o,
  output logic [BLINK_W-1:0]  div_o
);

  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS:0]   duty_shadow_q, duty_shadow_d;
  logic [PWM_BITS:0]   duty_active_q, duty_active_d;
  logic                pending_q, pending_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic [BLINK_W-1:0]  blink_div_q, blink_div_d;
  logic                phase_q, phase_d;
  logic                wrap;

  assign wrap = &pwm_cnt_q;

  // A write on the wrap edge wins: the new value waits for the next boundary.
  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    duty_shadow_d = duty_shadow_q;
    duty_active_d = duty_active_q;
    pending_d     = pending_q;
    if (wrap && pending_q) begin
      duty_active_d = duty_shadow_q;
      pending_d     = 1'b0;
    end
    if (duty_we_i) begin
      duty_shadow_d = duty_wdata_i;
      pending_d     = 1'b1;
    end
  end

  always_comb begin
    blink_div_d = blink_div_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (div_we_i) begin
      blink_div_d = div_wdata_i;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == blink_div_q) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      duty_shadow_q <= DUTY_FULL;
      duty_active_q <= DUTY_FULL;
      pending_q     <= 1'b0;
      blink_cnt_q   <= '0;
      blink_div_q   <= '1;
      phase_q       <= 1'b1;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      duty_shadow_q <= duty_shadow_d;
      duty_active_q <= duty_active_d;
      pending_q     <= pending_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_div_q   <= blink_div_d;
      phase_q       <= phase_d;
    end
  end

  assign pwm_on_o  = ({1'b0, pwm_cnt_q} < duty_active_q);
  assign phase_o   = phase_q;
  assign pending_o = pending_q;
  assign duty_o    = duty_shadow_q;
  assign div_o     = blink_div_q;

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED PIO with per-channel blink enable and a global PWM dimmer.
module led_pwm_pio
  import led_pwm_pio_pkg::*;
#(
  parameter int NUM_CH   = 14,
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] out_port
);

  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

  logic [NUM_CH-1:0]  data_q, data_d;
  logic [NUM_CH-1:0]  blink_en_q, blink_en_d;
  logic [NUM_CH-1:0]  out_port_q, out_port_d;
  logic [NUM_CH-1:0]  wdata_ch;
  logic               wr;
  logic               duty_we;
  logic               div_we;
  logic [PWM_BITS:0]  duty_wval;
  logic               pwm_on;
  logic               phase;
  logic               pending;
  logic [PWM_BITS:0]  duty_rd;
  logic [BLINK_W-1:0] div_rd;

  assign wr       = chipselect & ~write_n;
  assign wdata_ch = writedata[NUM_CH-1:0];
  assign duty_we  = wr && (address == ADDR_DUTY);
  assign div_we   = wr && (address == ADDR_BLINK_DIV);

  // Saturation looks at the whole bus word so oversized writes clamp to full-on.
  assign duty_wval = (writedata > 32'(DUTY_FULL)) ? DUTY_FULL : writedata[PWM_BITS:0];

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .BLINK_W  (BLINK_W)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .duty_we_i    (duty_we),
    .duty_wdata_i (duty_wval),
    .div_we_i     (div_we),
    .div_wdata_i  (writedata[BLINK_W-1:0]),
    .pwm_on_o     (pwm_on),
    .phase_o      (phase),
    .pending_o    (pending),
    .duty_o       (duty_rd),
    .div_o        (div_rd)
  );

  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d     = wdata_ch;
        ADDR_SET:      data_d     = data_q | wdata_ch;
        ADDR_CLEAR:    data_d     = data_q & ~wdata_ch;
        ADDR_BLINK_EN: blink_en_d = wdata_ch;
        default:       ;
      endcase
    end
  end

  assign out_port_d = data_q & {NUM_CH{pwm_on}} & (~blink_en_q | {NUM_CH{phase}});

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      blink_en_q <= '0;
      out_port_q <= '0;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      out_port_q <= out_port_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_q);
      ADDR_BLINK_EN:  readdata = 32'(blink_en_q);
      ADDR_BLINK_DIV: readdata = 32'(div_rd);
      ADDR_DUTY:      readdata = 32'(duty_rd);
      ADDR_STATUS:    readdata = status_word(phase, pending);
      default:        readdata = '0;
    endcase
  end

  assign out_port = out_port_q;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed and random checks of led_pwm_pio against a cycle-level behavioural model.
module tb_led_pwm_pio;
  import led_pwm_pio_pkg::*;

  localparam int NUM_CH     = 14;
  localparam int PWM_BITS   = 8;
  localparam int BLINK_W    = 24;
  localparam int PWM_PERIOD = 1 << PWM_BITS;
  localparam logic [31:0] CH_MASK  = (32'd1 << NUM_CH) - 32'd1;
  localparam logic [31:0] DIV_MASK = (32'd1 << BLINK_W) - 32'd1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        address = 3'd0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = 32'd0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] out_port;

  always #5 clk = ~clk;

  led_pwm_pio #(
    .NUM_CH   (NUM_CH),
    .PWM_BITS (PWM_BITS),
    .BLINK_W  (BLINK_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rd_seen;
  logic [31:0] out_seen;

  // reference model state
  logic [31:0] m_data, m_ben, m_div, m_shadow, m_active, m_out, m_bcnt;
  int          m_pwm;
  bit          m_pend, m_phase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_data   = 0;
    m_ben    = 0;
    m_div    = DIV_MASK;
    m_shadow = PWM_PERIOD;
    m_active = PWM_PERIOD;
    m_out    = 0;
    m_bcnt   = 0;
    m_pwm    = 0;
    m_pend   = 0;
    m_phase  = 1;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd3:    return m_ben;
      3'd4:    return m_div;
      3'd5:    return m_shadow;
      3'd6:    return {30'd0, m_pend, m_phase};
      default: return 0;
    endcase
  endfunction

  task automatic m_step(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                        input logic [31:0] wd);
    logic [31:0] nxt_out;
    if (rst) begin
      m_reset();
      return;
    end
    if (m_pwm < int'(m_active))
      nxt_out = m_data & (~m_ben | (m_phase ? CH_MASK : 32'd0)) & CH_MASK;
    else
      nxt_out = 0;
    if (m_pwm == PWM_PERIOD - 1 && m_pend) begin
      m_active = m_shadow;
      m_pend   = 0;
    end
    m_pwm = (m_pwm + 1) % PWM_PERIOD;
    if (m_bcnt == m_div) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_bcnt = m_bcnt + 1;
    end
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd & CH_MASK;
        3'd1: m_data = m_data | (wd & CH_MASK);
        3'd2: m_data = m_data & ~wd & CH_MASK;
        3'd3: m_ben  = wd & CH_MASK;
        3'd4: begin
          m_div   = wd & DIV_MASK;
          m_bcnt  = 0;
          m_phase = 1;
        end
        3'd5: begin
          m_shadow = (wd > 32'(PWM_PERIOD)) ? 32'(PWM_PERIOD) : wd;
          m_pend   = 1;
        end
        default: ;
      endcase
    end
    m_out = nxt_out;
  endtask

  task automatic cycle(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                       input logic [31:0] wd);
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    #3;
    rd_seen = readdata;
    check_eq($sformatf("readdata@%0d", a), rd_seen, m_read(a));
    @(posedge clk);
    m_step(rst, cs, wn, a, wd);
    #1;
    out_seen = 32'(out_port);
    check_eq("out_port", out_seen, m_out);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(0, 1, 0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(0, 1, 1, a, 32'hDEAD_BEEF);
  endtask

  // Wait for the pending duty to land, then count on-cycles of channel 0 over one period.
  task automatic wait_apply(output int ones);
    int n;
    n = 0;
    ones = 0;
    do begin
      rd(ADDR_STATUS);
      n++;
    end while (rd_seen[1] && n < 2 * PWM_PERIOD);
    check_eq("pending_clears", 32'(rd_seen[1]), 32'd0);
    ones = int'(out_seen[0]);
    for (int i = 1; i < PWM_PERIOD; i++) begin
      rd(ADDR_DATA);
      ones += int'(out_seen[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    bit r_rst, r_cs, r_wn;
    logic [2:0] r_a;
    logic [31:0] r_wd;

    reset = 1'b1;
    @(posedge clk);
    #1;
    m_reset();

    // reset state and plain DATA latch
    cycle(1, 0, 1, ADDR_DATA, 0);
    check_eq("rst_out", out_seen, 0);
    rd(ADDR_DUTY);
    check_eq("rst_duty", rd_seen, 32'd256);
    rd(ADDR_BLINK_DIV);
    check_eq("rst_div", rd_seen, 32'h00FF_FFFF);
    rd(ADDR_STATUS);
    check_eq("rst_status", rd_seen, 32'd1);
    wr(ADDR_DATA, 32'hFFFF_3FFF);
    check_eq("data_not_yet", out_seen, 0);
    rd(ADDR_DATA);
    check_eq("data_read", rd_seen, 32'h3FFF);
    check_eq("data_out", out_seen, 32'h3FFF);

    // SET / CLEAR
    wr(ADDR_DATA, 32'h00F0);
    wr(ADDR_SET, 32'h0003);
    wr(ADDR_CLEAR, 32'h0010);
    wr(ADDR_SET, 32'h0000);
    wr(ADDR_CLEAR, 32'h0000);
    rd(ADDR_DATA);
    check_eq("setclr_data", rd_seen, 32'h00E3);
    rd(ADDR_SET);
    check_eq("set_reads0", rd_seen, 0);
    rd(ADDR_CLEAR);
    check_eq("clr_reads0", rd_seen, 0);
    rd(3'd7);
    check_eq("addr7_reads0", rd_seen, 0);

    // duty: shadowed update, exact on-count per period
    wr(ADDR_DATA, 32'h1);
    repeat (37) rd(ADDR_DATA);
    wr(ADDR_DUTY, 32'd64);
    rd(ADDR_STATUS);
    check_eq("pending_set", 32'(rd_seen[1]), 32'd1);
    wait_apply(ones);
    check_eq("duty64_ones", 32'(ones), 32'd64);
    wr(ADDR_DUTY, 32'd0);
    wait_apply(ones);
    check_eq("duty0_ones", 32'(ones), 32'd0);
    wr(ADDR_DUTY, 32'd300);
    rd(ADDR_DUTY);
    check_eq("duty_sat_read", rd_seen, 32'd256);
    wait_apply(ones);
    check_eq("duty256_ones", 32'(ones), 32'd256);

    // blink
    wr(ADDR_BLINK_EN, 32'h1);
    wr(ADDR_BLINK_DIV, 32'd9);
    for (int i = 0; i < 30; i++) begin
      rd(ADDR_STATUS);
      check_eq($sformatf("blink9_%0d", i), 32'(out_seen[0]), 32'(((i / 10) % 2) == 0));
    end
    wr(ADDR_BLINK_DIV, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(ADDR_DATA);
      check_eq($sformatf("blink0_%0d", i), 32'(out_seen[0]), 32'((i % 2) == 0));
    end

    // reset with pending duty, active blink and a colliding write
    wr(ADDR_BLINK_DIV, 32'd3);
    wr(ADDR_DUTY, 32'd32);
    cycle(1, 1, 0, ADDR_DATA, 32'h0000_3FFF);
    check_eq("rst2_out", out_seen, 0);
    rd(ADDR_DUTY);
    check_eq("rst2_duty", rd_seen, 32'd256);
    rd(ADDR_STATUS);
    check_eq("rst2_status", rd_seen, 32'd1);
    rd(ADDR_DATA);
    check_eq("rst2_data", rd_seen, 0);
    rd(ADDR_BLINK_EN);
    check_eq("rst2_ben", rd_seen, 0);

    // random traffic against the model
    wr(ADDR_DATA, 32'h3FFF);
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_a   = 3'($urandom_range(0, 7));
      r_cs  = ($urandom_range(0, 3) != 0);
      r_wn  = ($urandom_range(0, 2) != 0);
      r_wd  = $urandom;
      if (r_a == ADDR_BLINK_DIV) r_wd = 32'($urandom_range(0, 12));
      if (r_a == ADDR_DUTY && $urandom_range(0, 3) != 0) r_wd = 32'($urandom_range(0, 300));
      cycle(r_rst, r_cs, r_wn, r_a, r_wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_pio.md
LED_PWM_PIO -- requirements
Module: led_pwm_pio

Interface
REQ-001 Parameter NUM_CH, default 14, output channel count, legal range 1..32.
REQ-002 Parameter PWM_BITS, default 8, PWM counter width, legal range 2..16.
REQ-003 Parameter BLINK_W, default 24, blink divider width, legal range 1..31.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, combinational from address (read latency 0).
REQ-011 out_port  output  NUM_CH  registered LED drive.

Function
REQ-012 Write accepted on a clock edge where chipselect=1 and write_n=0; no wait states; writedata bits above register width ignored.
REQ-013 Register map by address:
 - 0 DATA (R/W)
 - 1 SET (W; 1-bits OR into DATA)
 - 2 CLEAR (W; 1-bits clear DATA bits)
 - 3 BLINK_EN (R/W)
 - 4 BLINK_DIV (R/W, BLINK_W bits)
 - 5 DUTY (R/W, PWM_BITS+1 bits)
 - 6 STATUS (RO: bit0 blink phase, bit1 duty update pending)
 - 7 reserved.
REQ-014 Reads of SET, CLEAR, address 7 and all unused upper bits return 0.
REQ-015 Address 0 write/read behaviour is identical to the previous-generation LED PIO (plain NUM_CH-bit output latch).
REQ-016 PWM counter: PWM_BITS wide, increments every cycle, wraps from 2^PWM_BITS-1 to 0; wrap cycle is the period boundary.
REQ-017 pwm_on = (pwm_cnt < duty_active); duty_active=0 gives always off, duty_active=2^PWM_BITS gives always on.
REQ-018 DUTY writes above 2^PWM_BITS saturate to 2^PWM_BITS.
REQ-019 DUTY write loads a shadow register and sets pending; duty_active takes the shadow on the cycle pwm_cnt wraps to 0 and pending clears then (no mid-period glitch).
REQ-020 A second DUTY write while pending overwrites the shadow; only the last value is applied.
REQ-021 Blink counter: BLINK_W wide, increments every cycle; when equal to BLINK_DIV it returns to 0 and blink phase toggles.
REQ-022 BLINK_DIV=0 toggles phase every cycle.
REQ-023 BLINK_DIV write zeroes the blink counter and forces phase=1 on the same edge.
REQ-024 out_port[i] registered each cycle as DATA[i] & pwm_on & (~BLINK_EN[i] | phase).
REQ-025 Latency: register write at edge k is visible on out_port at edge k+1.
REQ-026 SET/CLEAR on already-set/clear bits have no effect; SET of 0 and CLEAR of 0 are no-ops.

Reset
REQ-027 While reset=1 on a clock edge: DATA, BLINK_EN, out_port, pwm_cnt, blink counter, pending = 0.
REQ-028 Reset values: DUTY shadow and duty_active = 2^PWM_BITS (full on); BLINK_DIV = 2^BLINK_W-1; phase = 1.
REQ-029 Reset mid-operation discards any pending duty update and in-flight write; reset dominates a simultaneous write.

Structure
REQ-030 Shared package led_pwm_pio_pkg holds register address constants (ADDR_DATA..ADDR_STATUS) and STATUS bit indices.
REQ-031 One sub-module led_pwm_timebase contains PWM counter, duty shadow/active logic and blink divider; outputs pwm_on, phase, pending.
REQ-032 Top holds the register file, read mux and output register.

Verification
REQ-033 Reset, write DATA=0x3FFF -> out_port=0x3FFF one cycle later, readdata addr0=0x3FFF, DUTY reads 256.
REQ-034 DATA=0x00F0, SET 0x0003, CLEAR 0x0010 -> DATA reads 0x00E3; SET/CLEAR reads return 0.
REQ-035 DATA=0x1, DUTY=64 written mid-period -> pending=1 until wrap; then out_port[0] high exactly 64 of every 256 cycles; DUTY=0 -> constant 0; DUTY=300 -> reads 256, constant 1.
REQ-036 BLINK_EN=0x1, BLINK_DIV=9 -> out_port[0] toggles every 10 cycles, first 10 high after the write; BLINK_DIV=0 -> toggles each cycle.
REQ-037 Assert reset with pending DUTY=32 and blink active -> all outputs 0 next cycle, DUTY reads 256, pending=0, phase=1.
